// File: rtl/conbus_slave_buf_pkg.sv
// Shared definitions for the conbus slave buffer: FSM state encodings and
// Wishbone cycle-type constants.
package conbus_slave_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/conbus_slave_buf.sv
// conbus_slave_buf: registered Wishbone slice between one conbus slave port and a
// slow/distant peripheral. Every output is a flop except m_ack_o, which is gated by
// the live m_cyc_i so an ack is never delivered to a master that has left the cycle.
// Optional watchdog: define CONBUS_SLAVE_BUF_TIMEOUT_EN to return a dummy ack
// (TIMEOUT_DATA) after TIMEOUT_CYCLES ack-less WAIT cycles.
module conbus_slave_buf
    import conbus_slave_buf_pkg::*;
#(
    parameter bit                   FORWARD_CTI    = 1'b0,
    parameter int unsigned          TIMEOUT_W      = 8,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 8'd255,
    parameter logic [31:0]          TIMEOUT_DATA   = 32'hdeadbeef
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    input  logic [3:0]  m_sel_i,
    input  logic [2:0]  m_cti_i,
    input  logic        m_we_i,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    output logic [31:0] m_dat_o,
    output logic        m_ack_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic [2:0]  s_cti_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic        timeout_o
);

    state_e      state_q;
    logic [31:0] m_dat_q;
    logic        ack_q;
    logic [31:0] s_adr_q;
    logic [31:0] s_dat_q;
    logic [3:0]  s_sel_q;
    logic [2:0]  s_cti_q;
    logic        s_we_q;
    logic        s_cyc_q;
    logic        abort_q;

    // The master has abandoned the cycle if cyc dropped at any point in WAIT,
    // including the cycle the peripheral finally acks.
    logic        abort_d;
    logic [2:0]  cti_d;

    assign abort_d = abort_q | ~m_cyc_i;
    assign cti_d   = FORWARD_CTI ? m_cti_i : CTI_CLASSIC;

`ifdef CONBUS_SLAVE_BUF_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic                 timeout_q;
    assign timeout_o = timeout_q;
`else
    // Watchdog parameters have no function in this build.
    logic unused_timeout;
    assign unused_timeout = ^{TIMEOUT_CYCLES, TIMEOUT_DATA};
    assign timeout_o      = 1'b0;
`endif

    // Request/response FSM; all bus-facing outputs are registered here.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            m_dat_q <= '0;
            ack_q   <= 1'b0;
            s_adr_q <= '0;
            s_dat_q <= '0;
            s_sel_q <= '0;
            s_cti_q <= '0;
            s_we_q  <= 1'b0;
            s_cyc_q <= 1'b0;
            abort_q <= 1'b0;
`ifdef CONBUS_SLAVE_BUF_TIMEOUT_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef CONBUS_SLAVE_BUF_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        s_adr_q <= m_adr_i;
                        s_dat_q <= m_dat_i;
                        s_sel_q <= m_sel_i;
                        s_cti_q <= cti_d;
                        s_we_q  <= m_we_i;
                        s_cyc_q <= 1'b1;
                        abort_q <= 1'b0;
`ifdef CONBUS_SLAVE_BUF_TIMEOUT_EN
                        wd_cnt_q <= '0;
`endif
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    abort_q <= abort_d;
                    if (s_ack_i) begin
                        // A real ack beats a watchdog expiry on the same cycle.
                        m_dat_q <= s_dat_i;
                        s_cyc_q <= 1'b0;
                        ack_q   <= ~abort_d;
                        state_q <= ST_ACK;
                    end
`ifdef CONBUS_SLAVE_BUF_TIMEOUT_EN
                    else if (wd_cnt_q == TIMEOUT_CYCLES) begin
                        m_dat_q   <= TIMEOUT_DATA;
                        s_cyc_q   <= 1'b0;
                        ack_q     <= ~abort_d;
                        timeout_q <= 1'b1;
                        state_q   <= ST_ACK;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                ST_ACK: begin
                    // Any request seen here is left for IDLE to pick up next cycle.
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_dat_o = m_dat_q;
    assign m_ack_o = ack_q & m_cyc_i;
    assign s_adr_o = s_adr_q;
    assign s_dat_o = s_dat_q;
    assign s_sel_o = s_sel_q;
    assign s_cti_o = s_cti_q;
    assign s_we_o  = s_we_q;
    assign s_cyc_o = s_cyc_q;
    assign s_stb_o = s_cyc_q;

endmodule

// File: tb/tb_conbus_slave_buf.sv
// Bench for conbus_slave_buf: directed transactions, a transaction-level reference
// model compared every cycle, and literal expectations for the headline cases.
// Honours CONBUS_SLAVE_BUF_TIMEOUT_EN the same way the design does.
module tb_conbus_slave_buf;

    localparam int          TO_CYC = 16;
    localparam logic [31:0] TO_DAT = 32'hdeadbeef;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] m_adr_i, m_dat_i, s_dat_i;
    logic [3:0]  m_sel_i;
    logic [2:0]  m_cti_i;
    logic        m_we_i, m_cyc_i, m_stb_i;
    logic [31:0] m_dat_o, s_adr_o, s_dat_o;
    logic        m_ack_o, s_we_o, s_cyc_o, s_stb_o, timeout_o;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic        s_ack_i;
    logic        ack_reg;
    logic        comb_ack;
    int          slave_delay;

    assign s_ack_i = comb_ack ? s_stb_o : ack_reg;

    conbus_slave_buf #(
        .FORWARD_CTI   (1'b1),
        .TIMEOUT_W     (8),
        .TIMEOUT_CYCLES(8'd16),
        .TIMEOUT_DATA  (TO_DAT)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .m_adr_i  (m_adr_i),
        .m_dat_i  (m_dat_i),
        .m_sel_i  (m_sel_i),
        .m_cti_i  (m_cti_i),
        .m_we_i   (m_we_i),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_cti_o  (s_cti_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .timeout_o(timeout_o)
    );

    always #5 sys_clk = ~sys_clk;

    int nchecks = 0;
    int nerr    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- peripheral: acks after slave_delay stb cycles (-1 = never)
    int stb_seen = 0;
    always @(posedge sys_clk) begin
        #1;
        if (s_stb_o && !ack_reg && slave_delay >= 0) begin
            if (stb_seen == slave_delay) begin
                ack_reg  = 1'b1;
                stb_seen = 0;
            end else begin
                stb_seen++;
            end
        end else begin
            ack_reg = 1'b0;
            if (!s_stb_o) stb_seen = 0;
        end
    end

    // ---------------- reference model (transaction level)
    // Inputs are snapshotted mid-cycle, then applied at the edge.
    bit          sn_rst = 0, sn_cyc = 0, sn_stb = 0, sn_we = 0, sn_ack = 0;
    logic [31:0] sn_adr, sn_dat, sn_sdat;
    logic [3:0]  sn_sel;
    logic [2:0]  sn_cti;

    bit          live = 0;
    bit          busy = 0;       // downstream cycle outstanding
    bit          replying = 0;   // the cycle in which the master gets its answer
    bit          deliver = 0;    // answer goes to the master (not abandoned)
    bit          expired = 0;    // answer came from the watchdog
    bit          abandoned = 0;
    int          idle_waits = 0; // ack-less cycles the peripheral has taken so far
    logic [31:0] e_adr, e_dat, e_mdat;
    logic [3:0]  e_sel;
    logic [2:0]  e_cti;
    logic        e_we;

    always @(posedge sys_clk) begin
        if (sn_rst) begin
            live = 1; busy = 0; replying = 0; deliver = 0; expired = 0;
            e_adr = 0; e_dat = 0; e_mdat = 0; e_sel = 0; e_cti = 0; e_we = 0;
        end else if (live) begin
            if (replying) begin
                replying = 0; deliver = 0; expired = 0;
            end else if (busy) begin
                abandoned = abandoned | !sn_cyc;
                if (sn_ack || (`ifdef CONBUS_SLAVE_BUF_TIMEOUT_EN idle_waits >= TO_CYC `else 1'b0 `endif)) begin
                    busy     = 0;
                    replying = 1;
                    deliver  = !abandoned;
                    expired  = !sn_ack;
                    e_mdat   = sn_ack ? sn_sdat : TO_DAT;
                end else begin
                    idle_waits++;
                end
            end else if (sn_cyc && sn_stb) begin
                busy = 1; abandoned = 0; idle_waits = 0;
                e_adr = sn_adr; e_dat = sn_dat; e_sel = sn_sel; e_cti = sn_cti; e_we = sn_we;
            end
        end
    end

    // ---------------- compare + monitors, mid-cycle
    int stb_cnt = 0, ack_cnt = 0, to_cnt = 0, starts = 0;
    logic stb_prev = 1'b0;
    always @(negedge sys_clk) begin
        if (live) begin
            chk("s_cyc_o", 32'(s_cyc_o), 32'(busy));
            chk("s_stb_o", 32'(s_stb_o), 32'(busy));
            chk("s_we_o", 32'(s_we_o), 32'(e_we));
            chk("s_adr_o", s_adr_o, e_adr);
            chk("s_dat_o", s_dat_o, e_dat);
            chk("s_sel_o", 32'(s_sel_o), 32'(e_sel));
            chk("s_cti_o", 32'(s_cti_o), 32'(e_cti));
            chk("m_dat_o", m_dat_o, e_mdat);
            chk("m_ack_o", 32'(m_ack_o), 32'(replying && deliver && m_cyc_i));
            chk("timeout_o", 32'(timeout_o), 32'(replying && expired));
        end
        if (s_stb_o === 1'b1) stb_cnt++;
        if (m_ack_o === 1'b1) ack_cnt++;
        if (timeout_o === 1'b1) to_cnt++;
        if (s_stb_o === 1'b1 && stb_prev !== 1'b1) starts++;
        stb_prev = s_stb_o;
        sn_rst = sys_rst; sn_cyc = m_cyc_i; sn_stb = m_stb_i; sn_we = m_we_i;
        sn_ack = s_ack_i; sn_adr = m_adr_i; sn_dat = m_dat_i; sn_sdat = s_dat_i;
        sn_sel = m_sel_i; sn_cti = m_cti_i;
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_req(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we, input logic [2:0] cti);
        m_adr_i = adr; m_dat_i = dat; m_sel_i = sel; m_we_i = we; m_cti_i = cti;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
    endtask

    task automatic drop();
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
    endtask

    // Edges from request until m_ack_o is visible.
    task automatic wait_ack(input int maxc, output int lat, output bit got);
        lat = 0; got = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            tick();
            lat++;
            got = m_ack_o;
        end
    endtask

    int lat, sb, ab, st, tb0;
    bit got;

    initial begin
        sys_rst = 1'b1; comb_ack = 1'b0; slave_delay = -1; ack_reg = 1'b0;
        m_adr_i = 0; m_dat_i = 0; m_sel_i = 0; m_cti_i = 0; m_we_i = 0;
        m_cyc_i = 0; m_stb_i = 0; s_dat_i = 0;
        repeat (3) tick();
        chk("reset_s_cyc", 32'(s_cyc_o), 0);
        chk("reset_m_ack", 32'(m_ack_o), 0);
        chk("reset_m_dat", m_dat_o, 0);
        sys_rst = 1'b0;
        tick();

        // 1: read, peripheral acks 3 cycles after stb
        slave_delay = 3; s_dat_i = 32'hcafe_0001; ab = ack_cnt;
        start_req(32'h6000_0010, 32'h0, 4'hf, 1'b0, 3'b010);
        wait_ack(30, lat, got);
        chk("rd_got_ack", 32'(got), 1);
        chk("rd_latency", 32'(lat), 5);
        chk("rd_m_dat", m_dat_o, 32'hcafe_0001);
        chk("rd_s_adr", s_adr_o, 32'h6000_0010);
        tick(); drop(); tick(); tick();
        chk("rd_ack_pulses", 32'(ack_cnt - ab), 1);

        // 2: write with combinational peripheral ack
        slave_delay = -1; comb_ack = 1'b1; sb = stb_cnt; s_dat_i = 32'h5555_aaaa;
        start_req(32'h6000_0020, 32'h1234_5678, 4'b0011, 1'b1, 3'b000);
        wait_ack(30, lat, got);
        chk("wr_got_ack", 32'(got), 1);
        chk("wr_latency", 32'(lat), 2);
        chk("wr_s_dat", s_dat_o, 32'h1234_5678);
        chk("wr_s_sel", 32'(s_sel_o), 32'h3);
        tick(); drop(); tick();
        chk("wr_stb_cycles", 32'(stb_cnt - sb), 1);
        comb_ack = 1'b0;

        // 3: back-to-back, new address right after the ack
        slave_delay = 1; st = starts; ab = ack_cnt; s_dat_i = 32'h0bad_f00d;
        start_req(32'h6000_0100, 32'h1, 4'hf, 1'b0, 3'b111);
        wait_ack(30, lat, got);
        chk("b2b_got_ack1", 32'(got), 1);
        tick();
        m_adr_i = 32'h6000_0200;
        tick();
        chk("b2b_s_adr2", s_adr_o, 32'h6000_0200);
        wait_ack(30, lat, got);
        chk("b2b_got_ack2", 32'(got), 1);
        tick(); drop(); repeat (4) tick();
        chk("b2b_starts", 32'(starts - st), 2);
        chk("b2b_acks", 32'(ack_cnt - ab), 2);

        // 4: master abort in WAIT, peripheral acks later
        slave_delay = 5; ab = ack_cnt; sb = stb_cnt;
        start_req(32'h6000_0300, 32'h2, 4'hf, 1'b0, 3'b000);
        tick(); tick();
        drop();
        repeat (12) tick();
        chk("abort_no_ack", 32'(ack_cnt - ab), 0);
        chk("abort_stb_cycles", 32'(stb_cnt - sb), 6);
        chk("abort_s_cyc", 32'(s_cyc_o), 0);

        // 5: peripheral never acks
        slave_delay = -1; sb = stb_cnt; tb0 = to_cnt;
        start_req(32'h6000_0400, 32'h3, 4'hf, 1'b0, 3'b000);
`ifdef CONBUS_SLAVE_BUF_TIMEOUT_EN
        wait_ack(60, lat, got);
        chk("to_got_ack", 32'(got), 1);
        chk("to_latency", 32'(lat), TO_CYC + 2);
        chk("to_pulse_with_ack", 32'(timeout_o), 1);
        chk("to_m_dat", m_dat_o, 32'hdeadbeef);
        chk("to_stb_cycles", 32'(stb_cnt - sb), TO_CYC + 1);
        tick(); drop(); tick();
        chk("to_s_cyc", 32'(s_cyc_o), 0);
        chk("to_pulses", 32'(to_cnt - tb0), 1);
        start_req(32'h6000_0500, 32'h4, 4'hf, 1'b0, 3'b000);
        tick(); tick();
`else
        wait_ack(1000, lat, got);
        chk("noto_no_ack", 32'(got), 0);
        chk("noto_s_cyc_held", 32'(s_cyc_o), 1);
        chk("noto_no_pulse", 32'(to_cnt - tb0), 0);
`endif

        // 6: reset while WAIT is outstanding
        sys_rst = 1'b1; drop();
        tick();
        chk("rst_s_cyc", 32'(s_cyc_o), 0);
        chk("rst_s_stb", 32'(s_stb_o), 0);
        chk("rst_s_we", 32'(s_we_o), 0);
        chk("rst_s_adr", s_adr_o, 0);
        chk("rst_s_dat", s_dat_o, 0);
        chk("rst_s_sel", 32'(s_sel_o), 0);
        chk("rst_s_cti", 32'(s_cti_o), 0);
        chk("rst_m_dat", m_dat_o, 0);
        chk("rst_m_ack", 32'(m_ack_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        sys_rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", 32'(s_cyc_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "global timeout");
    end

endmodule
